// File: rtl/axis_hermitian_mapper.sv
// DCO-OFDM subcarrier mapper: buffers one frame of constellation symbols, then emits
// N bins with DC/Nyquist zeroed and the upper half filled with the Hermitian mirror.
module axis_hermitian_mapper #(
    parameter int FFT_LEN = 64
) (
    input  logic        aclk,
    input  logic        areset,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser
);

    localparam int IW   = $clog2(FFT_LEN);
    localparam int CW   = IW - 1;
    localparam int HALF = FFT_LEN / 2;
    localparam int D    = HALF - 1;
    localparam logic [IW-1:0] LAST_BIN = IW'(FFT_LEN - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [31:0]   sym_buf_r [HALF];
    logic [CW-1:0] wr_cnt_r;
    logic [IW-1:0] out_idx_r;
    logic          eop_r;
    logic          s_tready_r;
    logic          m_tvalid_r;
    logic          m_tlast_r;
    logic          m_tuser_r;
    logic [31:0]   m_tdata_r;

    logic          fill_hs_s;
    logic          out_hs_s;
    logic          fill_done_s;
    logic          frame_done_s;
    logic [IW-1:0] nxt_idx_s;
    logic [CW-1:0] bin_lo_s;
    logic [CW-1:0] mir_s;
    logic [31:0]   bin_s;

    // Q negation saturates so that -32768 does not wrap back onto itself.
    function automatic logic [31:0] conj_sym(input logic [31:0] sym);
        logic [15:0] q;
        if (sym[31:16] == 16'h8000) begin
            q = 16'h7FFF;
        end else begin
            q = 16'h0000 - sym[31:16];
        end
        return {q, sym[15:0]};
    endfunction

    // Handshake qualification and frame-boundary detection.
    always_comb begin
        fill_hs_s    = (state_r == S_FILL) && s_tready_r && s_axis_tvalid;
        out_hs_s     = (state_r == S_OUT) && m_tvalid_r && m_axis_tready;
        fill_done_s  = fill_hs_s && (s_axis_tlast || (wr_cnt_r == CW'(D - 1)));
        frame_done_s = out_hs_s && (out_idx_r == LAST_BIN);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FILL: begin
                if (fill_done_s) begin
                    state_nxt_s = S_OUT;
                end else begin
                    state_nxt_s = S_FILL;
                end
            end
            S_OUT: begin
                if (frame_done_s) begin
                    state_nxt_s = S_FILL;
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            default: state_nxt_s = S_FILL;
        endcase
    end

    // Value of the bin that follows out_idx; low bits alone identify DC/Nyquist and the mirror slot.
    always_comb begin
        nxt_idx_s = out_idx_r + IW'(1);
        bin_lo_s  = nxt_idx_s[CW-1:0];
        mir_s     = CW'(0) - bin_lo_s;
        bin_s     = 32'h0000_0000;
        if (bin_lo_s == '0) begin
            bin_s = 32'h0000_0000;
        end else if (!nxt_idx_s[IW-1]) begin
            if (bin_lo_s <= wr_cnt_r) begin
                bin_s = sym_buf_r[bin_lo_s];
            end else begin
                bin_s = 32'h0000_0000;
            end
        end else begin
            if (mir_s <= wr_cnt_r) begin
                bin_s = conj_sym(sym_buf_r[mir_s]);
            end else begin
                bin_s = 32'h0000_0000;
            end
        end
    end

    // Symbol storage; slot 0 is never used because bin 0 is always zero.
    always_ff @(posedge aclk) begin
        if (fill_hs_s && !areset) begin
            sym_buf_r[wr_cnt_r + CW'(1)] <= s_axis_tdata;
        end
    end

    // Control state and registered output stage.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= S_FILL;
            wr_cnt_r   <= '0;
            out_idx_r  <= '0;
            eop_r      <= 1'b0;
            s_tready_r <= 1'b0;
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= 32'h0000_0000;
            m_tlast_r  <= 1'b0;
            m_tuser_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            s_tready_r <= (state_nxt_s == S_FILL);
            if (fill_hs_s) begin
                wr_cnt_r <= wr_cnt_r + CW'(1);
                eop_r    <= s_axis_tlast;
            end
            if (fill_done_s) begin
                m_tvalid_r <= 1'b1;
                out_idx_r  <= '0;
                m_tdata_r  <= 32'h0000_0000;
                m_tlast_r  <= 1'b0;
                m_tuser_r  <= 1'b0;
            end else if (frame_done_s) begin
                m_tvalid_r <= 1'b0;
                out_idx_r  <= '0;
                wr_cnt_r   <= '0;
                eop_r      <= 1'b0;
                m_tdata_r  <= 32'h0000_0000;
                m_tlast_r  <= 1'b0;
                m_tuser_r  <= 1'b0;
            end else if (out_hs_s) begin
                out_idx_r <= nxt_idx_s;
                m_tdata_r <= bin_s;
                m_tlast_r <= (nxt_idx_s == LAST_BIN);
                m_tuser_r <= eop_r && (nxt_idx_s == LAST_BIN);
            end
        end
    end

    assign s_axis_tready = s_tready_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tlast  = m_tlast_r;
    assign m_axis_tuser  = m_tuser_r;

endmodule

// File: tb/tb_axis_hermitian_mapper.sv
// Directed bench for axis_hermitian_mapper: one FFT_LEN=8 and one FFT_LEN=64 instance.
module tb_axis_hermitian_mapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, s8_tready, s8_tvalid, s8_tlast, m8_tready, m8_tvalid, m8_tlast, m8_tuser;
    logic [31:0] s8_tdata, m8_tdata;
    logic        rst64, s64_tready, s64_tvalid, s64_tlast, m64_tready, m64_tvalid, m64_tlast, m64_tuser;
    logic [31:0] s64_tdata, m64_tdata;

    int n_checks = 0;
    int n_fail   = 0;

    axis_hermitian_mapper #(.FFT_LEN(8)) dut8 (
        .aclk(clk), .areset(rst8),
        .s_axis_tready(s8_tready), .s_axis_tdata(s8_tdata), .s_axis_tvalid(s8_tvalid),
        .s_axis_tlast(s8_tlast), .m_axis_tready(m8_tready), .m_axis_tdata(m8_tdata),
        .m_axis_tvalid(m8_tvalid), .m_axis_tlast(m8_tlast), .m_axis_tuser(m8_tuser)
    );

    axis_hermitian_mapper #(.FFT_LEN(64)) dut64 (
        .aclk(clk), .areset(rst64),
        .s_axis_tready(s64_tready), .s_axis_tdata(s64_tdata), .s_axis_tvalid(s64_tvalid),
        .s_axis_tlast(s64_tlast), .m_axis_tready(m64_tready), .m_axis_tdata(m64_tdata),
        .m_axis_tvalid(m64_tvalid), .m_axis_tlast(m64_tlast), .m_axis_tuser(m64_tuser)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int i, input int q);
        return {q[15:0], i[15:0]};
    endfunction

    function automatic logic [31:0] tb_conj(input logic [31:0] d);
        logic [15:0] q;
        q = d[31:16];
        if (q == 16'h8000) q = 16'h7FFF;
        else q = -q;
        return {q, d[15:0]};
    endfunction

    function automatic logic [31:0] model_bin(input logic [31:0] q[$], input int base,
                                              input int cnt, input int n, input int k);
        if (k == 0 || k == n / 2) return 32'h0;
        if (k < n / 2) return (k <= cnt) ? q[base + k - 1] : 32'h0;
        return (n - k <= cnt) ? tb_conj(q[base + n - k - 1]) : 32'h0;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send8(input logic [31:0] d, input logic l);
        int t = 0;
        s8_tdata = d; s8_tlast = l; s8_tvalid = 1'b1;
        while (s8_tready !== 1'b1 && t < 500) begin @(negedge clk); t++; end
        check("send8_ready", 32'(s8_tready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send64(input logic [31:0] d, input logic l);
        int t = 0;
        s64_tdata = d; s64_tlast = l; s64_tvalid = 1'b1;
        while (s64_tready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        check("send64_ready", 32'(s64_tready), 32'd1);
        @(negedge clk);
    endtask

    task automatic recv8(input logic [31:0] e[8], input logic tu, input string tag);
        for (int k = 0; k < 8; k++) begin
            int t = 0;
            while (m8_tvalid !== 1'b1 && t < 500) begin @(negedge clk); t++; end
            check($sformatf("%s_valid%0d", tag, k), 32'(m8_tvalid), 32'd1);
            check($sformatf("%s_bin%0d", tag, k), m8_tdata, e[k]);
            check($sformatf("%s_last%0d", tag, k), 32'(m8_tlast), 32'(k == 7));
            check($sformatf("%s_user%0d", tag, k), 32'(m8_tuser), 32'((k == 7) && tu));
            check($sformatf("%s_sready%0d", tag, k), 32'(s8_tready), 32'd0);
            @(negedge clk);
        end
    endtask

    // Random back-pressure; expected value is held per bin so any change during a stall is caught.
    task automatic collect64(input logic [31:0] q[$], input int nfr, input logic tu, input string tag);
        int idx = 0;
        int t   = 0;
        while (idx < 64 * nfr && t < 20000) begin
            m64_tready = 1'($urandom_range(0, 1));
            if (m64_tvalid === 1'b1) begin
                check($sformatf("%s_bin%0d", tag, idx), m64_tdata,
                      model_bin(q, (idx / 64) * 31, 31, 64, idx % 64));
                check($sformatf("%s_last%0d", tag, idx), 32'(m64_tlast), 32'((idx % 64) == 63));
                check($sformatf("%s_user%0d", tag, idx), 32'(m64_tuser), 32'(((idx % 64) == 63) && tu));
                check($sformatf("%s_sready%0d", tag, idx), 32'(s64_tready), 32'd0);
                if (m64_tready) idx++;
            end
            @(negedge clk);
            t++;
        end
        check({tag, "_count"}, 32'(idx), 32'(64 * nfr));
        m64_tready = 1'b1;
    endtask

    initial begin
        logic [31:0] e[8];
        logic [31:0] s6[$];
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        int hs;
        int t;

        rst8 = 1'b1; rst64 = 1'b1;
        s8_tdata = '0; s8_tvalid = 1'b0; s8_tlast = 1'b0; m8_tready = 1'b1;
        s64_tdata = '0; s64_tvalid = 1'b0; s64_tlast = 1'b0; m64_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sready8", 32'(s8_tready), 32'd0);
        check("rst_mvalid8", 32'(m8_tvalid), 32'd0);
        check("rst_tdata8", m8_tdata, 32'd0);
        check("rst_tlast8", 32'(m8_tlast), 32'd0);
        check("rst_tuser8", 32'(m8_tuser), 32'd0);
        check("rst_sready64", 32'(s64_tready), 32'd0);
        rst8 = 1'b0; rst64 = 1'b0;
        @(negedge clk);
        check("rel_sready8", 32'(s8_tready), 32'd1);
        check("rel_sready64", 32'(s64_tready), 32'd1);

        // Full frame without tlast
        send8(pk(100, 200), 1'b0);
        send8(pk(300, -400), 1'b0);
        send8(pk(-500, 600), 1'b0);
        s8_tvalid = 1'b0;
        e = '{32'h0, pk(100, 200), pk(300, -400), pk(-500, 600),
              32'h0, pk(-500, -600), pk(300, 400), pk(100, -200)};
        recv8(e, 1'b0, "t1");
        check("t1_idle_valid", 32'(m8_tvalid), 32'd0);
        check("t1_idle_sready", 32'(s8_tready), 32'd1);

        // Short packet, zero padded; bin 0 must be valid right after the last handshake
        send8(pk(7, 8), 1'b0);
        send8(pk(9, 10), 1'b1);
        s8_tvalid = 1'b0; s8_tlast = 1'b0;
        check("t2_latency", 32'(m8_tvalid), 32'd1);
        e = '{32'h0, pk(7, 8), pk(9, 10), 32'h0, 32'h0, 32'h0, pk(9, -10), pk(7, -8)};
        recv8(e, 1'b1, "t2");

        // Saturating conjugate
        send8(pk(5, -32768), 1'b0);
        send8(pk(1, 32767), 1'b1);
        s8_tvalid = 1'b0; s8_tlast = 1'b0;
        e = '{32'h0, pk(5, -32768), pk(1, 32767), 32'h0, 32'h0, 32'h0, pk(1, -32767), pk(5, 32767)};
        recv8(e, 1'b1, "t3");

        // Continuous input, tlast every third symbol
        for (int j = 1; j <= 9; j++) s6.push_back(pk(11 * j, 1000 - j));
        fork
            begin
                for (int j = 1; j <= 9; j++) send8(s6[j - 1], 1'(j % 3 == 0));
                s8_tvalid = 1'b0; s8_tlast = 1'b0;
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int k = 0; k < 8; k++) e[k] = model_bin(s6, 3 * f, 3, 8, k);
                    recv8(e, 1'b1, $sformatf("t6f%0d", f));
                end
            end
        join

        // Two full 64-bin frames under random back-pressure
        for (int j = 0; j < 62; j++) qa.push_back(pk(37 * j - 1000, 500 - 13 * j));
        fork
            begin
                for (int j = 0; j < 62; j++) send64(qa[j], 1'b0);
                s64_tvalid = 1'b0;
            end
            collect64(qa, 2, 1'b0, "t4");
        join

        // Reset while bin 20 is on the bus; old frame must vanish
        qa.delete();
        for (int j = 0; j < 31; j++) qa.push_back(pk(j + 1, j + 2));
        m64_tready = 1'b1;
        for (int j = 0; j < 31; j++) send64(qa[j], 1'b0);
        s64_tvalid = 1'b0;
        hs = 0; t = 0;
        while (hs < 20 && t < 1000) begin
            if (m64_tvalid === 1'b1) hs++;
            @(negedge clk);
            t++;
        end
        check("t5_bin20", m64_tdata, model_bin(qa, 0, 31, 64, 20));
        rst64 = 1'b1;
        @(negedge clk);
        check("t5_rst_valid", 32'(m64_tvalid), 32'd0);
        check("t5_rst_tdata", m64_tdata, 32'd0);
        check("t5_rst_sready", 32'(s64_tready), 32'd0);
        rst64 = 1'b0;
        @(negedge clk);
        check("t5_rel_sready", 32'(s64_tready), 32'd1);
        check("t5_rel_valid", 32'(m64_tvalid), 32'd0);
        for (int j = 0; j < 31; j++) qb.push_back(pk(-j - 3, 7 * j));
        fork
            begin
                for (int j = 0; j < 31; j++) send64(qb[j], 1'(j == 30));
                s64_tvalid = 1'b0; s64_tlast = 1'b0;
            end
            collect64(qb, 1, 1'b1, "t5");
        join
        @(negedge clk);
        check("t5_end_valid", 32'(m64_tvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
